// File: rtl/output_port_credit_pkg.sv
// Shared definitions for the credit-based BFT output port: default geometry,
// packet field offset helpers, transmit FSM states and credit counter width.
package output_port_credit_pkg;

   localparam int PACKET_BITS_DEF           = 97;
   localparam int NUM_LEAF_BITS_DEF         = 6;
   localparam int NUM_PORT_BITS_DEF         = 4;
   localparam int PAYLOAD_BITS_DEF          = 64;
   localparam int NUM_BRAM_ADDR_BITS_DEF    = 7;
   localparam int FREESPACE_UPDATE_SIZE_DEF = 64;
   localparam int FIFO_DEPTH_BITS_DEF       = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_SEND = 2'd2
   } txState_t;

   // Topmost packet bit marks the packet as valid.
   function automatic int validBitOf(input int packetBits);
      return packetBits - 1;
   endfunction

   // Destination leaf field sits directly below the valid bit.
   function automatic int leafLsbOf(input int packetBits, input int leafBits);
      return packetBits - 1 - leafBits;
   endfunction

   // Destination port field sits directly below the leaf field.
   function automatic int portLsbOf(input int packetBits, input int leafBits, input int portBits);
      return packetBits - 1 - leafBits - portBits;
   endfunction

   // One extra bit so a full remote buffer (2**addrBits words) is representable.
   function automatic int creditWidth(input int addrBits);
      return addrBits + 1;
   endfunction

endpackage

// File: rtl/output_port_fifo.sv
// Synchronous skid FIFO in front of the packet register. Full and empty are
// registered so the user-facing ready never depends on same-cycle logic.
module output_port_fifo
   import output_port_credit_pkg::*;
#(
   parameter int WIDTH      = PAYLOAD_BITS_DEF,
   parameter int DEPTH_BITS = FIFO_DEPTH_BITS_DEF
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam logic [DEPTH_BITS:0] DEPTH_CNT = {1'b1, {DEPTH_BITS{1'b0}}};

   logic [WIDTH-1:0]      mem_q [2**DEPTH_BITS];
   logic [DEPTH_BITS-1:0] wrPtr_q, wrPtr_d;
   logic [DEPTH_BITS-1:0] rdPtr_q, rdPtr_d;
   logic [DEPTH_BITS:0]   count_q, count_d;
   logic                  full_q, full_d;
   logic                  empty_q, empty_d;
   logic                  doPush;
   logic                  doPop;

   assign doPush  = push_i & ~full_q;
   assign doPop   = pop_i & ~empty_q;
   assign data_o  = mem_q[rdPtr_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;

   // Pointer, occupancy and flag next-state; flags derive from the next count.
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (doPush) begin
         wrPtr_d = wrPtr_q + DEPTH_BITS'(1);
      end
      if (doPop) begin
         rdPtr_d = rdPtr_q + DEPTH_BITS'(1);
      end
      if (doPush && !doPop) begin
         count_d = count_q + (DEPTH_BITS+1)'(1);
      end else if (doPop && !doPush) begin
         count_d = count_q - (DEPTH_BITS+1)'(1);
      end
      full_d  = (count_d == DEPTH_CNT);
      empty_d = (count_d == '0);
   end

   // Control state register with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
         full_q  <= full_d;
         empty_q <= empty_d;
      end
   end

   // Storage array needs no reset; occupancy tracking guards every read.
   always_ff @(posedge clk_i) begin
      if (doPush) begin
         mem_q[wrPtr_q] <= data_i;
      end
   end

endmodule

// File: rtl/output_port_credit.sv
// Credit-based BFT output port. User words are buffered in a small FIFO,
// wrapped into packets addressed by out_control_reg and offered to the leaf
// arbiter only while credits (free remote buffer words) remain.
// Optional build macro OUTPUT_PORT_STATS_EN adds sent_cnt/stall_cnt outputs.
module output_port_credit
   import output_port_credit_pkg::*;
#(
   parameter int PACKET_BITS           = PACKET_BITS_DEF,
   parameter int NUM_LEAF_BITS         = NUM_LEAF_BITS_DEF,
   parameter int NUM_PORT_BITS         = NUM_PORT_BITS_DEF,
   parameter int PAYLOAD_BITS          = PAYLOAD_BITS_DEF,
   parameter int NUM_BRAM_ADDR_BITS    = NUM_BRAM_ADDR_BITS_DEF,
   parameter int FREESPACE_UPDATE_SIZE = FREESPACE_UPDATE_SIZE_DEF,
   parameter int FIFO_DEPTH_BITS       = FIFO_DEPTH_BITS_DEF
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [PAYLOAD_BITS-1:0]                din_user,
   input  logic                                   vld_user,
   output logic                                   ack_b_out2user,
   input  logic [NUM_LEAF_BITS+NUM_PORT_BITS-1:0] out_control_reg,
   input  logic                                   freespace_update,
   output logic [PACKET_BITS-1:0]                 packet_out,
   output logic                                   packet_out_req,
   input  logic                                   packet_out_grant,
   output logic                                   credit_error
`ifdef OUTPUT_PORT_STATS_EN
   ,
   output logic [31:0]                            sent_cnt,
   output logic [31:0]                            stall_cnt
`endif
);

   localparam int VALID_BIT = validBitOf(PACKET_BITS);
   localparam int LEAF_LSB  = leafLsbOf(PACKET_BITS, NUM_LEAF_BITS);
   localparam int PORT_LSB  = portLsbOf(PACKET_BITS, NUM_LEAF_BITS, NUM_PORT_BITS);
   localparam int CW        = creditWidth(NUM_BRAM_ADDR_BITS);

   localparam logic [CW-1:0] CREDIT_MAX = {1'b1, {NUM_BRAM_ADDR_BITS{1'b0}}};
   localparam logic [CW-1:0] ONE_CREDIT = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW:0]   UPDATE_AMT = (CW+1)'(FREESPACE_UPDATE_SIZE);

   txState_t                 state_q, state_d;
   logic [CW-1:0]            credit_q, credit_d;
   logic                     creditError_q, creditError_d;
   logic [PACKET_BITS-1:0]   packet_q, packet_d;
   logic [PACKET_BITS-1:0]   loadPacket;
   logic [CW:0]              creditSum;
   logic [PAYLOAD_BITS-1:0]  fifoData;
   logic                     fifoFull;
   logic                     fifoEmpty;
   logic                     fifoPush;
   logic                     fifoPop;
   logic                     granted;

   assign ack_b_out2user = reset & ~fifoFull;
   assign fifoPush       = vld_user & ack_b_out2user;
   assign fifoPop        = (state_q == ST_LOAD);
   assign granted        = (state_q == ST_SEND) & packet_out_grant;
   assign packet_out     = packet_q;
   assign packet_out_req = (state_q == ST_SEND);
   assign credit_error   = creditError_q;

   output_port_fifo #(
      .WIDTH      (PAYLOAD_BITS),
      .DEPTH_BITS (FIFO_DEPTH_BITS)
   ) u_fifo (
      .clk_i    (clk),
      .reset_ni (reset),
      .push_i   (fifoPush),
      .pop_i    (fifoPop),
      .data_i   (din_user),
      .data_o   (fifoData),
      .full_o   (fifoFull),
      .empty_o  (fifoEmpty)
   );

   // Packet assembly from the FIFO head; the destination is taken at load time.
   always_comb begin
      loadPacket = '0;
      loadPacket[VALID_BIT] = 1'b1;
      loadPacket[LEAF_LSB +: NUM_LEAF_BITS] = out_control_reg[NUM_PORT_BITS +: NUM_LEAF_BITS];
      loadPacket[PORT_LSB +: NUM_PORT_BITS] = out_control_reg[0 +: NUM_PORT_BITS];
      loadPacket[0 +: PAYLOAD_BITS] = fifoData;
   end

   // Transmit FSM: wait for data and credit, load one word, hold until granted.
   always_comb begin
      state_d  = state_q;
      packet_d = packet_q;
      case (state_q)
         ST_IDLE: begin
            if (!fifoEmpty && credit_q != '0) begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            packet_d = loadPacket;
            state_d  = ST_SEND;
         end
         ST_SEND: begin
            if (packet_out_grant) begin
               state_d = (!fifoEmpty && credit_q > ONE_CREDIT) ? ST_LOAD : ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Credit bookkeeping with one spare bit so overflow past the maximum is visible.
   always_comb begin
      creditSum     = {1'b0, credit_q};
      creditError_d = creditError_q;
      if (granted) begin
         creditSum = creditSum - (CW+1)'(1);
      end
      if (freespace_update) begin
         creditSum = creditSum + UPDATE_AMT;
      end
      credit_d = creditSum[CW-1:0];
      if (creditSum > {1'b0, CREDIT_MAX}) begin
         credit_d      = CREDIT_MAX;
         creditError_d = 1'b1;
      end
   end

   // State, credit and packet registers; reset discards any packet in flight.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         credit_q      <= CREDIT_MAX;
         creditError_q <= 1'b0;
         packet_q      <= '0;
      end else begin
         state_q       <= state_d;
         credit_q      <= credit_d;
         creditError_q <= creditError_d;
         packet_q      <= packet_d;
      end
   end

`ifdef OUTPUT_PORT_STATS_EN
   logic [31:0] sentCnt_q;
   logic [31:0] stallCnt_q;

   assign sent_cnt  = sentCnt_q;
   assign stall_cnt = stallCnt_q;

   // Free-running wrap-around counters of granted packets and credit stalls.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sentCnt_q  <= '0;
         stallCnt_q <= '0;
      end else begin
         if (granted) begin
            sentCnt_q <= sentCnt_q + 32'd1;
         end
         if (!fifoEmpty && credit_q == '0) begin
            stallCnt_q <= stallCnt_q + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_output_port_credit.sv
// Testbench for output_port_credit: random payloads through a queue-based
// reference model of credits, ordering and packet contents, plus directed
// latency, stall, overflow and reset scenarios.
module tb_output_port_credit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [63:0] din_user = '0;
   logic        vld_user = 1'b0;
   logic        ack_b_out2user;
   logic [9:0]  out_control_reg = '0;
   logic        freespace_update = 1'b0;
   logic [96:0] packet_out;
   logic        packet_out_req;
   logic        packet_out_grant = 1'b0;
   logic        credit_error;
`ifdef OUTPUT_PORT_STATS_EN
   logic [31:0] sent_cnt;
   logic [31:0] stall_cnt;
`endif

   int          compared = 0;
   int          mismatched = 0;
   logic [63:0] txQ[$];
   logic [63:0] modelQ[$];
   int          modelCredit = 128;
   bit          modelErr = 1'b0;
   int          sentTotal = 0;
   int          stallModel = 0;
   bit          takeNow = 1'b0;
   int          base;

   always #5 clk = ~clk;

   output_port_credit dut (
      .clk              (clk),
      .reset            (reset),
      .din_user         (din_user),
      .vld_user         (vld_user),
      .ack_b_out2user   (ack_b_out2user),
      .out_control_reg  (out_control_reg),
      .freespace_update (freespace_update),
      .packet_out       (packet_out),
      .packet_out_req   (packet_out_req),
      .packet_out_grant (packet_out_grant),
      .credit_error     (credit_error)
`ifdef OUTPUT_PORT_STATS_EN
      ,
      .sent_cnt         (sent_cnt),
      .stall_cnt        (stall_cnt)
`endif
   );

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input int cycles);
      repeat (cycles) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic applyReset();
      reset = 1'b0;
      txQ.delete();
      freespace_update = 1'b0;
      applyStimulus(2);
      reset = 1'b1;
   endtask

   task automatic pushWords(input int n);
      for (int i = 0; i < n; i++) begin
         txQ.push_back({$urandom, $urandom});
      end
   endtask

   task automatic pulseUpdate();
      freespace_update = 1'b1;
      applyStimulus(1);
      freespace_update = 1'b0;
   endtask

   task automatic waitForReq(input int maxCycles);
      int n = 0;
      while (!packet_out_req && n < maxCycles) begin
         applyStimulus(1);
         n++;
      end
      checkOutput("req_wait", packet_out_req, 1'b1);
   endtask

   // User-side driver: presents the head of txQ and retires it once accepted.
   always begin
      @(posedge clk);
      #1;
      if (takeNow && txQ.size() > 0) begin
         void'(txQ.pop_front());
      end
      if (txQ.size() > 0) begin
         vld_user = 1'b1;
         din_user = txQ[0];
      end else begin
         vld_user = 1'b0;
         din_user = '0;
      end
   end

   // Reference model: words in flight, remote credit and sticky error flag.
   always @(negedge clk) begin
      logic [96:0] expPkt;
      if (!reset) begin
         modelQ.delete();
         modelCredit = 128;
         modelErr = 1'b0;
         sentTotal = 0;
         stallModel = 0;
         takeNow = 1'b0;
      end else begin
         checkOutput("credit_error", credit_error, modelErr);
         if (modelCredit == 0) begin
            checkOutput("req_without_credit", packet_out_req, 1'b0);
         end
`ifdef OUTPUT_PORT_STATS_EN
         checkOutput("sent_cnt", sent_cnt, sentTotal);
         checkOutput("stall_cnt", stall_cnt, stallModel);
`endif
         if (modelCredit == 0 && modelQ.size() > 0) begin
            stallModel++;
         end
         takeNow = vld_user && ack_b_out2user;
         if (takeNow) begin
            modelQ.push_back(din_user);
         end
         if (packet_out_req && packet_out_grant) begin
            checkOutput("packet_expected", modelQ.size() > 0, 1'b1);
            checkOutput("credit_at_grant", modelCredit > 0, 1'b1);
            if (modelQ.size() > 0) begin
               expPkt = {1'b1, out_control_reg[9:4], out_control_reg[3:0], 22'd0, modelQ[0]};
               checkOutput("packet_out", packet_out, expPkt);
               void'(modelQ.pop_front());
            end
            modelCredit--;
            sentTotal++;
         end
         if (freespace_update) begin
            modelCredit += 64;
         end
         if (modelCredit > 128) begin
            modelCredit = 128;
            modelErr = 1'b1;
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      // Reset values while reset is held low.
      applyStimulus(2);
      checkOutput("rst_ack", ack_b_out2user, 1'b0);
      checkOutput("rst_req", packet_out_req, 1'b0);
      checkOutput("rst_packet", packet_out, 97'd0);
      checkOutput("rst_credit_error", credit_error, 1'b0);

      // Single word: request two cycles after the push, header leaf 3 / port 2.
      out_control_reg = {6'd3, 4'd2};
      packet_out_grant = 1'b1;
      reset = 1'b1;
      applyStimulus(1);
      checkOutput("ack_after_reset", ack_b_out2user, 1'b1);
      txQ.push_back(64'hA5);
      applyStimulus(2);
      checkOutput("lat_req_c0", packet_out_req, 1'b0);
      applyStimulus(1);
      checkOutput("lat_req_c1", packet_out_req, 1'b0);
      applyStimulus(1);
      checkOutput("lat_req_c2", packet_out_req, 1'b1);
      checkOutput("lat_packet", packet_out, {1'b1, 6'd3, 4'd2, 22'd0, 64'hA5});
      applyStimulus(1);
      checkOutput("lat_req_drop", packet_out_req, 1'b0);

      // 130 more words with 127 credits left: exactly 127 go out, then stall.
      out_control_reg = {6'd17, 4'd11};
      base = sentTotal;
      pushWords(130);
      applyStimulus(400);
      checkOutput("burst_sent", sentTotal - base, 127);
      checkOutput("burst_req_low", packet_out_req, 1'b0);
      checkOutput("burst_left", modelQ.size(), 3);
      checkOutput("burst_all_taken", txQ.size(), 0);

      // One update restores 64 credits: 64 further packets then stall again.
      base = sentTotal;
      pulseUpdate();
      pushWords(70);
      applyStimulus(300);
      checkOutput("resume_sent", sentTotal - base, 64);
      checkOutput("resume_req_low", packet_out_req, 1'b0);
      checkOutput("resume_left", modelQ.size(), 9);

      // Grant and update together at credit 10 leave 73 credits.
      applyReset();
      out_control_reg = {6'd60, 4'd5};
      packet_out_grant = 1'b1;
      pushWords(118);
      applyStimulus(400);
      checkOutput("pre10_sent", sentTotal, 118);
      packet_out_grant = 1'b0;
      pushWords(1);
      waitForReq(20);
      freespace_update = 1'b1;
      packet_out_grant = 1'b1;
      applyStimulus(1);
      freespace_update = 1'b0;
      base = sentTotal;
      pushWords(80);
      applyStimulus(300);
      checkOutput("credit73_sent", sentTotal - base, 73);
      checkOutput("credit73_left", modelQ.size(), 7);
      checkOutput("credit73_req_low", packet_out_req, 1'b0);
      checkOutput("credit73_no_error", credit_error, 1'b0);

      // Backpressure: with grant low the FIFO fills and ack drops.
      applyReset();
      out_control_reg = {6'd45, 4'd9};
      packet_out_grant = 1'b0;
      pushWords(20);
      applyStimulus(40);
      checkOutput("full_ack_low", ack_b_out2user, 1'b0);
      checkOutput("full_held", modelQ.size(), 17);
      checkOutput("full_waiting", txQ.size(), 3);
      checkOutput("full_req", packet_out_req, 1'b1);
      packet_out_grant = 1'b1;
      applyStimulus(80);
      checkOutput("drain_sent", sentTotal, 20);
      checkOutput("drain_empty", modelQ.size(), 0);
      checkOutput("drain_ack", ack_b_out2user, 1'b1);

      // Update at full credit: clamp, sticky error, still only 128 packets.
      applyReset();
      applyStimulus(1);
      checkOutput("ovf_before", credit_error, 1'b0);
      pulseUpdate();
      checkOutput("ovf_set", credit_error, 1'b1);
      applyStimulus(5);
      checkOutput("ovf_sticky", credit_error, 1'b1);
      out_control_reg = {6'd1, 4'd15};
      packet_out_grant = 1'b1;
      pushWords(130);
      applyStimulus(400);
      checkOutput("ovf_sent", sentTotal, 128);
      checkOutput("ovf_left", modelQ.size(), 2);
      checkOutput("ovf_req_low", packet_out_req, 1'b0);

      // Reset while a packet waits for grant: everything returns to reset values.
      packet_out_grant = 1'b0;
      pulseUpdate();
      waitForReq(20);
      reset = 1'b0;
      txQ.delete();
      applyStimulus(1);
      checkOutput("midrst_req", packet_out_req, 1'b0);
      checkOutput("midrst_packet", packet_out, 97'd0);
      checkOutput("midrst_ack", ack_b_out2user, 1'b0);
      checkOutput("midrst_error", credit_error, 1'b0);
      applyStimulus(1);
      reset = 1'b1;
      applyStimulus(5);
      checkOutput("postrst_req", packet_out_req, 1'b0);
      checkOutput("postrst_ack", ack_b_out2user, 1'b1);
      packet_out_grant = 1'b1;
      pushWords(1);
      applyStimulus(10);
      checkOutput("postrst_sent", sentTotal, 1);
      checkOutput("postrst_empty", modelQ.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
